// File: rtl/mmc1_write_sequencer.sv
// ---------------------------------------------------------------------------
// mmc1_write_sequencer
//
// Host-side bus master that loads one MMC1 mapper register through the
// mapper's 5-write serial port. One register write is accepted per
// valid/ready handshake. The block then emits the CPU-side bus cycles that
// the mapper latches on, with an optional serial-port reset write first.
//
// Ports
//   i_sys_clk      system clock, all state on rising edge
//   i_sys_rst      asynchronous active-high reset
//   i_req_valid    request present
//   o_req_ready    request can be accepted (high only in IDLE)
//   i_req_reg      target register: 00 control, 01 CHR0, 10 CHR1, 11 PRG
//   i_req_data     5-bit value, shifted out LSB first
//   i_req_reset    prepend one D7=1 serial-port reset write
//   o_busy         sequence in progress
//   o_done         one-cycle pulse when the sequence completes
//   o_cpu_m2       free-running M2 clock to the mapper
//   o_ncpu_romsel  active-low ROM select
//   o_ncpu_rw      low = write
//   o_cpu_a14/a13  register select
//   o_cpu_d7       serial reset bit
//   o_cpu_d0       serial data bit
//
// State table
//   state  | meaning
//   IDLE   | waiting for a request, o_req_ready high
//   ALIGN  | request latched, waiting for the phase counter to wrap to 0
//   RSTWR  | one M2 period write with D7=1 (serial port reset)
//   BITWR  | one M2 period write carrying data bit r_bit on D0
//   GAP    | GAP_CYCLES idle M2 periods between writes
//
// GAP_CYCLES=0 produces back-to-back write periods. Real MMC1 silicon
// ignores writes on consecutive CPU cycles, so 0 only suits behavioural
// mapper models.
// ---------------------------------------------------------------------------
module mmc1_write_sequencer #(
    parameter int M2_DIV     = 3,
    parameter int GAP_CYCLES = 1
) (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic [1:0] i_req_reg,
    input  logic [4:0] i_req_data,
    input  logic       i_req_reset,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_cpu_m2,
    output logic       o_ncpu_romsel,
    output logic       o_ncpu_rw,
    output logic       o_cpu_a14,
    output logic       o_cpu_a13,
    output logic       o_cpu_d7,
    output logic       o_cpu_d0
);

    localparam int PH_MAX   = 2 * M2_DIV - 1;
    localparam int PW       = $clog2(2 * M2_DIV);
    localparam int GAP_LD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int GW       = (GAP_LD_I > 0) ? $clog2(GAP_LD_I + 1) : 1;

    localparam logic [PW-1:0] PH_LAST = PW'(PH_MAX);
    localparam logic [PW-1:0] PH_M2   = PW'(M2_DIV);
    localparam logic [PW-1:0] PH_SEL  = PW'(M2_DIV + 1);
    localparam logic [GW-1:0] GAP_LD  = GW'(GAP_LD_I);
    localparam logic [2:0]    N_BITS  = 3'd5;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_RSTWR = 3'd2;
    localparam logic [2:0] S_BITWR = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]    r_state;
    logic [PW-1:0] r_ph;
    logic [2:0]    r_bit;
    logic [GW-1:0] r_gap;
    logic [1:0]    r_reg;
    logic [4:0]    r_data;
    logic          r_rst_req;

    logic          r_ready;
    logic          r_busy;
    logic          r_done;
    logic          r_m2;
    logic          r_romsel_n;
    logic          r_rw_n;
    logic          r_a14;
    logic          r_a13;
    logic          r_d7;
    logic          r_d0;

    logic [2:0]    w_state_nxt;
    logic [PW-1:0] w_ph_nxt;
    logic [2:0]    w_bit_nxt;
    logic [GW-1:0] w_gap_nxt;
    logic          w_done_nxt;
    logic          w_accept;
    logic          w_wrap;
    logic          w_wr_nxt;
    logic          w_wr_start;
    logic          w_d0_nxt;

    // Phase counter runs in every state; writes always start at ph=0.
    assign w_wrap   = (r_ph == PH_LAST);
    assign w_ph_nxt = w_wrap ? '0 : r_ph + PW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_gap_nxt   = r_gap;
        w_done_nxt  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    w_accept    = 1'b1;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (w_wrap) begin
                    w_state_nxt = r_rst_req ? S_RSTWR : S_BITWR;
                end
            end
            S_RSTWR: begin
                if (w_wrap) begin
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = GAP_LD;
                    end else begin
                        w_state_nxt = S_BITWR;
                    end
                end
            end
            S_BITWR: begin
                if (w_wrap) begin
                    w_bit_nxt = r_bit + 3'd1;
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = GAP_LD;
                    end else if (w_bit_nxt == N_BITS) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_BITWR;
                    end
                end
            end
            S_GAP: begin
                // r_gap is a down-counter of idle periods still to run.
                if (w_wrap) begin
                    if (r_gap == '0) begin
                        if (r_bit == N_BITS) begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_BITWR;
                        end
                    end else begin
                        w_gap_nxt = r_gap - GW'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs are registered from next-state/next-phase so that they
    // line up exactly with the registered M2 edge of the same phase.
    assign w_wr_nxt   = (w_state_nxt == S_RSTWR) || (w_state_nxt == S_BITWR);
    assign w_wr_start = w_wr_nxt && (w_ph_nxt == '0);
    assign w_d0_nxt   = (w_state_nxt == S_BITWR) ? r_data[w_bit_nxt] : 1'b0;

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_state    <= S_IDLE;
            r_ph       <= '0;
            r_bit      <= '0;
            r_gap      <= '0;
            r_reg      <= '0;
            r_data     <= '0;
            r_rst_req  <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_m2       <= 1'b0;
            r_romsel_n <= 1'b1;
            r_rw_n     <= 1'b1;
            r_a14      <= 1'b0;
            r_a13      <= 1'b0;
            r_d7       <= 1'b0;
            r_d0       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ph       <= w_ph_nxt;
            r_bit      <= w_bit_nxt;
            r_gap      <= w_gap_nxt;
            if (w_accept) begin
                r_reg     <= i_req_reg;
                r_data    <= i_req_data;
                r_rst_req <= i_req_reset;
            end
            r_ready    <= (w_state_nxt == S_IDLE);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= w_done_nxt;
            r_m2       <= (w_ph_nxt >= PH_M2);
            // ROMSEL trails the M2 rise by one clock and releases with M2 fall.
            r_romsel_n <= ~(w_wr_nxt && (w_ph_nxt >= PH_SEL));
            r_rw_n     <= ~w_wr_nxt;
            // Address and data hold between writes until the next write drives them.
            if (w_wr_start) begin
                r_a14 <= r_reg[1];
                r_a13 <= r_reg[0];
                r_d7  <= (w_state_nxt == S_RSTWR);
                r_d0  <= w_d0_nxt;
            end
        end
    end

    assign o_req_ready   = r_ready;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_cpu_m2      = r_m2;
    assign o_ncpu_romsel = r_romsel_n;
    assign o_ncpu_rw     = r_rw_n;
    assign o_cpu_a14     = r_a14;
    assign o_cpu_a13     = r_a13;
    assign o_cpu_d7      = r_d7;
    assign o_cpu_d0      = r_d0;

endmodule
